// File: rtl/cfi_shadow_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cfi_shadow_stack                                             |
// | Description : Commit-stage shadow return-address stack; flags returns      |
// |               whose next committed PC differs from the pushed link addr.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package cfi_shadow_stack_pkg;
    localparam int unsigned NR_COMMIT_PORTS = 2;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        JAL  = 4'd1,
        JALR = 4'd2,
        BEQ  = 4'd3,
        LD   = 4'd4
    } fu_op_t;

    typedef struct packed {
        logic [63:0] pc;
        fu_op_t      op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic        is_compressed;
    } scoreboard_entry_t;
endpackage

module cfi_shadow_stack
    import cfi_shadow_stack_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
    input  logic [NR_COMMIT_PORTS-1:0]            commit_ack_i,
    input  logic                                  flush_i,
    output logic                                  violation_o,
    output logic [CNT_W-1:0]                      violation_cnt_o,
    output logic                                  underflow_o,
    output logic                                  overflow_o,
    output logic [$clog2(DEPTH):0]                depth_o
);
    localparam int unsigned           c_PTR_W   = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]      c_FULL    = (c_PTR_W+1)'(DEPTH);
    localparam logic [c_PTR_W:0]      c_CNT_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0]    c_PTR_ONE = c_PTR_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CHECK = 1'b1
    } state_e;

    state_e                r_state, w_state;
    logic [c_PTR_W-1:0]    r_top, w_top;
    logic [c_PTR_W:0]      r_count, w_count;
    logic [ADDR_W-1:0]     r_expected, w_expected;
    logic [ADDR_W-1:0]     r_stack [DEPTH];
    logic [ADDR_W-1:0]     w_stack [DEPTH];
    logic                  r_violation, w_violation;
    logic                  r_underflow, w_underflow;
    logic                  r_overflow, w_overflow;
    logic [CNT_W-1:0]      r_vcnt;

    logic [NR_COMMIT_PORTS-1:0] w_call, w_ret;
    logic [ADDR_W-1:0]          w_link [NR_COMMIT_PORTS];

    always_comb begin
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            w_call[i] = (commit_instr_i[i].op == JAL || commit_instr_i[i].op == JALR) &&
                        (commit_instr_i[i].rd == 5'd1 || commit_instr_i[i].rd == 5'd5);
            w_ret[i]  = (commit_instr_i[i].op == JALR) && (commit_instr_i[i].rd == 5'd0) &&
                        (commit_instr_i[i].rs1 == 5'd1 || commit_instr_i[i].rs1 == 5'd5);
            w_link[i] = commit_instr_i[i].pc[ADDR_W-1:0] +
                        (commit_instr_i[i].is_compressed ? ADDR_W'(2) : ADDR_W'(4));
        end
    end

    // Slots are walked in order so slot 1 observes slot 0's stack/FSM update.
    always_comb begin
        w_state     = r_state;
        w_top       = r_top;
        w_count     = r_count;
        w_expected  = r_expected;
        w_stack     = r_stack;
        w_violation = 1'b0;
        w_underflow = 1'b0;
        w_overflow  = r_overflow;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (!flush_i && commit_ack_i[i]) begin
                if (w_state == S_CHECK) begin
                    if (commit_instr_i[i].pc[ADDR_W-1:0] != w_expected) begin
                        w_violation = 1'b1;
                    end
                    w_state = S_IDLE;
                end
                if (w_call[i]) begin
                    // When full, the advancing top lands on the oldest entry.
                    w_top          = w_top + c_PTR_ONE;
                    w_stack[w_top] = w_link[i];
                    if (w_count == c_FULL) begin
                        w_overflow = 1'b1;
                    end else begin
                        w_count = w_count + c_CNT_ONE;
                    end
                end else if (w_ret[i]) begin
                    if (w_count != '0) begin
                        w_expected = w_stack[w_top];
                        w_top      = w_top - c_PTR_ONE;
                        w_count    = w_count - c_CNT_ONE;
                        w_state    = S_CHECK;
                    end else begin
                        w_underflow = 1'b1;
                    end
                end
            end
        end
        if (flush_i) begin
            w_state    = S_IDLE;
            w_top      = '0;
            w_count    = '0;
            w_overflow = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_top       <= '0;
            r_count     <= '0;
            r_expected  <= '0;
            r_violation <= 1'b0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
            r_vcnt      <= '0;
        end else begin
            r_state     <= w_state;
            r_top       <= w_top;
            r_count     <= w_count;
            r_expected  <= w_expected;
            r_violation <= w_violation;
            r_underflow <= w_underflow;
            r_overflow  <= w_overflow;
            if (w_violation && (r_vcnt != {CNT_W{1'b1}})) begin
                r_vcnt <= r_vcnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        r_stack <= w_stack;
    end

    assign violation_o     = r_violation;
    assign violation_cnt_o = r_vcnt;
    assign underflow_o     = r_underflow;
    assign overflow_o      = r_overflow;
    assign depth_o         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_cfi_shadow_stack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cfi_shadow_stack                                          |
// | Description : Scoreboard bench with a queue-based return-stack model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cfi_shadow_stack;
    import cfi_shadow_stack_pkg::*;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned CNT_W  = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    scoreboard_entry_t [1:0]   commit_instr_i;
    logic [1:0]                commit_ack_i;
    logic                      flush_i;
    logic                      violation_o;
    logic [CNT_W-1:0]          violation_cnt_o;
    logic                      underflow_o;
    logic                      overflow_o;
    logic [$clog2(DEPTH):0]    depth_o;

    cfi_shadow_stack #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .commit_instr_i  (commit_instr_i),
        .commit_ack_i    (commit_ack_i),
        .flush_i         (flush_i),
        .violation_o     (violation_o),
        .violation_cnt_o (violation_cnt_o),
        .underflow_o     (underflow_o),
        .overflow_o      (overflow_o),
        .depth_o         (depth_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       v;
        int         cnt;
        logic       u;
        logic       o;
        int         d;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;

    // Reference model state
    logic [63:0] m_stk[$];
    logic        m_pend = 1'b0;
    logic [63:0] m_exp = '0;
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("violation_o", longint'(violation_o), longint'(mon_e.v));
            chk("violation_cnt_o", longint'(violation_cnt_o), longint'(mon_e.cnt));
            chk("underflow_o", longint'(underflow_o), longint'(mon_e.u));
            chk("overflow_o", longint'(overflow_o), longint'(mon_e.o));
            chk("depth_o", longint'(depth_o), longint'(mon_e.d));
        end
    end

    function automatic logic is_call(input scoreboard_entry_t e);
        return (e.op == JAL || e.op == JALR) && (e.rd == 5'd1 || e.rd == 5'd5);
    endfunction

    function automatic logic is_ret(input scoreboard_entry_t e);
        return (e.op == JALR) && (e.rd == 5'd0) && (e.rs1 == 5'd1 || e.rs1 == 5'd5);
    endfunction

    task automatic model_step(input logic [1:0] ack, input scoreboard_entry_t s0,
                              input scoreboard_entry_t s1, input logic fl);
        scoreboard_entry_t s [2];
        exp_t e;
        logic v;
        logic u;
        v = 1'b0;
        u = 1'b0;
        s[0] = s0;
        s[1] = s1;
        if (fl) begin
            m_stk.delete();
            m_pend = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ack[i]) begin
                    if (m_pend) begin
                        if (s[i].pc != m_exp) v = 1'b1;
                        m_pend = 1'b0;
                    end
                    if (is_call(s[i])) begin
                        if (m_stk.size() == DEPTH) begin
                            void'(m_stk.pop_front());
                            m_ovf = 1'b1;
                        end
                        m_stk.push_back(s[i].pc + (s[i].is_compressed ? 64'd2 : 64'd4));
                    end else if (is_ret(s[i])) begin
                        if (m_stk.size() > 0) begin
                            m_exp  = m_stk.pop_back();
                            m_pend = 1'b1;
                        end else begin
                            u = 1'b1;
                        end
                    end
                end
            end
        end
        if (v && m_cnt < CNT_MAX) m_cnt++;
        e.v = v;
        e.cnt = m_cnt;
        e.u = u;
        e.o = m_ovf;
        e.d = m_stk.size();
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_pend = 1'b0;
        m_ovf  = 1'b0;
        m_cnt  = 0;
    endtask

    // Drive at the falling edge, return just after the rising edge that consumes it.
    task automatic cycle(input logic [1:0] ack, input scoreboard_entry_t s0,
                         input scoreboard_entry_t s1, input logic fl);
        @(negedge clk_i);
        commit_instr_i[0] = s0;
        commit_instr_i[1] = s1;
        commit_ack_i = ack;
        flush_i = fl;
        model_step(ack, s0, s1, fl);
        @(posedge clk_i);
        #2;
    endtask

    function automatic scoreboard_entry_t mk(input fu_op_t op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [63:0] pc,
                                             input logic c);
        scoreboard_entry_t e;
        e.op = op;
        e.rd = rd;
        e.rs1 = rs1;
        e.pc = pc;
        e.is_compressed = c;
        return e;
    endfunction

    function automatic scoreboard_entry_t call_at(input logic [63:0] pc, input logic c);
        return mk(JAL, 5'd1, 5'd0, pc, c);
    endfunction

    function automatic scoreboard_entry_t ret_at(input logic [63:0] pc);
        return mk(JALR, 5'd0, 5'd1, pc, 1'b0);
    endfunction

    function automatic scoreboard_entry_t oth_at(input logic [63:0] pc);
        return mk(ADD, 5'd2, 5'd3, pc, 1'b0);
    endfunction

    function automatic logic [4:0] rnd_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            default: return 5'd2;
        endcase
    endfunction

    function automatic scoreboard_entry_t rnd_entry();
        scoreboard_entry_t e;
        logic [63:0] g;
        if (m_pend)                g = m_exp;
        else if (m_stk.size() > 0) g = m_stk[$];
        else                       g = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       e.op = JAL;
            1:       e.op = JALR;
            2:       e.op = ADD;
            default: e.op = LD;
        endcase
        e.rd = rnd_reg();
        e.rs1 = rnd_reg();
        e.is_compressed = 1'($urandom_range(0, 1));
        e.pc = ($urandom_range(0, 2) != 0) ? g : {$urandom, $urandom};
        return e;
    endfunction

    task automatic reset_now();
        #1;
        rst_ni = 1'b0;
        commit_ack_i = '0;
        flush_i = 1'b0;
        #1;
        model_reset();
        chk("reset violation_o", longint'(violation_o), 0);
        chk("reset violation_cnt_o", longint'(violation_cnt_o), 0);
        chk("reset underflow_o", longint'(underflow_o), 0);
        chk("reset overflow_o", longint'(overflow_o), 0);
        chk("reset depth_o", longint'(depth_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    scoreboard_entry_t nop_e;

    initial begin
        nop_e = oth_at(64'h0);
        commit_instr_i[0] = nop_e;
        commit_instr_i[1] = nop_e;
        commit_ack_i = '0;
        flush_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        reset_now();

        // Matched call/return
        cycle(2'b01, call_at(64'h8000_0100, 1'b0), nop_e, 1'b0);
        chk("t1 depth after call", longint'(depth_o), 1);
        cycle(2'b00, nop_e, nop_e, 1'b0);
        cycle(2'b01, ret_at(64'h8000_0500), nop_e, 1'b0);
        chk("t1 depth after ret", longint'(depth_o), 0);
        cycle(2'b01, oth_at(64'h8000_0104), nop_e, 1'b0);
        chk("t1 no violation", longint'(violation_o), 0);
        chk("t1 count", longint'(violation_cnt_o), 0);

        // Redirected return
        cycle(2'b01, call_at(64'h8000_0100, 1'b0), nop_e, 1'b0);
        cycle(2'b01, ret_at(64'h8000_0500), nop_e, 1'b0);
        cycle(2'b01, oth_at(64'h8000_0200), nop_e, 1'b0);
        chk("t2 violation", longint'(violation_o), 1);
        chk("t2 count", longint'(violation_cnt_o), 1);
        cycle(2'b00, nop_e, nop_e, 1'b0);
        chk("t2 pulse ends", longint'(violation_o), 0);

        // Compressed call, return and target in the same cycle
        cycle(2'b01, call_at(64'h8000_0100, 1'b1), nop_e, 1'b0);
        cycle(2'b11, ret_at(64'h8000_0600), oth_at(64'h8000_0102), 1'b0);
        cycle(2'b00, nop_e, nop_e, 1'b0);
        chk("t3 no violation", longint'(violation_cnt_o), 1);
        chk("t3 depth", longint'(depth_o), 0);

        // Return on an empty stack
        cycle(2'b01, ret_at(64'h8000_0700), nop_e, 1'b0);
        chk("t4 underflow", longint'(underflow_o), 1);
        cycle(2'b01, oth_at(64'hDEAD_0000), nop_e, 1'b0);
        chk("t4 unchecked", longint'(violation_o), 0);

        // Overflow, then drain
        for (int k = 0; k < 9; k++)
            cycle(2'b01, call_at(64'h1000 + 64'(16 * k), 1'b0), nop_e, 1'b0);
        chk("t5 depth full", longint'(depth_o), 8);
        chk("t5 overflow", longint'(overflow_o), 1);
        for (int k = 8; k >= 1; k--) begin
            cycle(2'b01, ret_at(64'h2000), nop_e, 1'b0);
            cycle(2'b01, oth_at(64'h1000 + 64'(16 * k) + 64'd4), nop_e, 1'b0);
        end
        chk("t5 no violations", longint'(violation_cnt_o), 1);
        cycle(2'b01, ret_at(64'h2000), nop_e, 1'b0);
        chk("t5 underflow", longint'(underflow_o), 1);

        // Flush while a check is pending
        cycle(2'b01, call_at(64'h8000_0100, 1'b0), nop_e, 1'b0);
        cycle(2'b01, ret_at(64'h8000_0500), nop_e, 1'b0);
        cycle(2'b00, nop_e, nop_e, 1'b1);
        cycle(2'b01, oth_at(64'h8000_0900), nop_e, 1'b0);
        chk("t6 no violation", longint'(violation_o), 0);
        chk("t6 depth", longint'(depth_o), 0);
        chk("t6 overflow cleared", longint'(overflow_o), 0);

        // Reset while a check is pending
        cycle(2'b01, call_at(64'h8000_0100, 1'b0), nop_e, 1'b0);
        cycle(2'b01, ret_at(64'h8000_0500), nop_e, 1'b0);
        reset_now();
        cycle(2'b01, oth_at(64'h8000_0900), nop_e, 1'b0);
        chk("t7 no violation", longint'(violation_o), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            scoreboard_entry_t r0;
            scoreboard_entry_t r1;
            r0 = rnd_entry();
            r1 = rnd_entry();
            cycle(2'($urandom_range(0, 3)), r0, r1, ($urandom_range(0, 29) == 0));
            if (n == 1700) reset_now();
        end

        cycle(2'b00, nop_e, nop_e, 1'b0);
        chk("scoreboard drained", longint'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
